decode: RTL and testbench
=========================

# decode

Second pipeline stage of the CPU: consumes `pcD`/`instrD` from the fetch pipeline register and produces the ID/EX pipeline register for execute. It holds the 32×`WORD` integer register file (x0 hardwired to zero), writes it from the writeback stage, and bypasses same-cycle writebacks. It generates RV32I immediates and control signals, and supports hazard-unit stall and flush.

## Interface
Parameters:
- `REGS_POWER`, default 5: log2 of the register count; fixes `rs1`/`rs2`/`rd` width.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: reset, asynchronous and active-low; clears the ID/EX register and the register file.
- `pcD` input `WORD`: PC of the instruction in decode.
- `instrD` input `WORD`: instruction word in decode.
- `RegWriteW` input 1: writeback enable.
- `rdW` input 5: writeback destination.
- `resultW` input `WORD`: writeback data.
- `stallE` input 1: hold the ID/EX register.
- `flushE` input 1: load a bubble into the ID/EX register.
- `rs1D`, `rs2D` output 5: combinational source fields of `instrD`, for the hazard unit.
- `pcE` output `WORD`: registered PC.
- `rs1valE`, `rs2valE` output `WORD`: registered operand values.
- `immE` output `WORD`: registered sign-extended immediate.
- `rs1E`, `rs2E`, `rdE` output 5: registered register indices.
- `funct3E` output 3: registered funct3.
- `aluctrlE` output 4: ALU op.
- `srcAE` output 2: ALU A source. 0 = rs1, 1 = pc, 2 = zero.
- `srcBE` output 1: ALU B source. 0 = rs2, 1 = imm.
- `RegWriteE`, `MemReadE`, `MemWriteE`, `BranchE`, `JumpE`, `JalrE`, `IllegalE` output 1: control flags.

## Operation
- **Field extraction:** `rs1D` = `instrD[19:15]`, `rs2D` = `instrD[24:20]`, rd = `instrD[11:7]`, opcode = `instrD[6:0]`.
- **Immediates:** I, S, B, U and J per RV32I, sign-extended from bit 31. B and J have bit 0 = 0. U is `{instr[31:12], 12'b0}`. R-type immediate is 0.
- **Register file read:** combinational.
  - Index 0 returns 0.
  - If `RegWriteW` is 1, `rdW` is nonzero and `rdW` equals the source index, return `resultW` (write-through bypass).
- **Register file write:** at the rising edge when `RegWriteW` is 1 and `rdW` is nonzero. Writes to x0 are dropped.
- **`aluctrlE` encoding:** `{bit30, funct3}`.
  - bit30 = `instr[30]` for OP, and for OP-IMM with funct3 = 101.
  - bit30 = 0 for every other OP-IMM.
  - Loads, stores, LUI, AUIPC, JAL, JALR: 4'b0000 (ADD).
  - Branches: 4'b1000 (SUB). Execute uses `funct3E` for the branch condition.
- **Per-opcode control:**

| Opcode | srcA | srcB | Flags |
|---|---|---|---|
| LUI | zero | imm | RegWrite |
| AUIPC | pc | imm | RegWrite |
| JAL | pc | imm | Jump, RegWrite |
| JALR | rs1 | imm | Jalr, RegWrite |
| BRANCH | rs1 | rs2 | Branch |
| LOAD | rs1 | imm | MemRead, RegWrite |
| STORE | rs1 | imm | MemWrite |
| OP-IMM | rs1 | imm | RegWrite |
| OP | rs1 | rs2 | RegWrite |

- **`RegWriteE` with rd = 0:** forced to 0.
- **Bubble:** `instrD` = 0 (fetch-register reset value) decodes as a bubble. All control flags are 0 and `IllegalE` = 0.
- **Illegal:** any other unlisted opcode, or OP with funct7 not equal to 0000000/0100000, gives `IllegalE` = 1 with all other control flags 0.
- **ID/EX register, priority reset > flushE > stallE > load:**
  - flushE: every registered output becomes 0 (bubble).
  - stallE: all outputs hold.
  - otherwise: load the decoded values.

## Timing
- **Reset:** asserting `reset` low immediately (asynchronously) clears every registered output and all 32 registers to 0. Release takes effect at the next rising edge.
- **Decode latency:** one cycle, from `instrD` at edge N to the `*E` outputs after edge N+1.
- **Write-then-read:** a writeback presented in cycle N is visible to decode in the same cycle N through the bypass. The array holds the value from edge N+1 onward.
- **Simultaneous events:**
  - `flushE` and `stallE` together: flush wins.
  - `stallE` held: the register-file write still occurs. Operands are re-read only when the register loads.
- **`rs1D`/`rs2D`:** purely combinational, no latency.

## Test plan
- **Reset:** reset low mid-run with the ID/EX register loaded → all `*E` outputs 0 immediately. Then read x5 → 0.
- **ADDI:** `instrD` = 0x00500093 (addi x1,x0,5), `pcD` = 0x10 → next cycle: `immE` = 5, `rdE` = 1, `srcAE` = 0, `srcBE` = 1, `aluctrlE` = 0, `RegWriteE` = 1, `pcE` = 0x10.
- **Bypass:** `RegWriteW` = 1, `rdW` = 3, `resultW` = 0xDEADBEEF, same cycle as `instrD` = add x4,x3,x0 → `rs1valE` = 0xDEADBEEF. `rdW` = 0 with `resultW` = 7 → x0 reads 0.
- **Immediates:** `instrD` = 0xFE000EE3 (beq x0,x0,-4) → `immE` = 0xFFFFFFFC, `BranchE` = 1, `aluctrlE` = 4'b1000. JAL 0x800000EF → `immE` = 0xFFF00000.
- **Stall/flush:** load SUB, then assert `stallE` for 2 cycles → outputs unchanged. Assert `stallE` and `flushE` together → all outputs 0.
- **Illegal and bubble:** `instrD` = 0xFFFFFFFF → `IllegalE` = 1, `RegWriteE` = 0. `instrD` = 0 → all flags 0, `IllegalE` = 0.

Source files
------------

// File: rtl/decode.sv
// rtl/decode.sv - RV32I decode stage: register file with write-through bypass, immediate/control generation, ID/EX register
module decode #(
  parameter int REGS_POWER = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           pcD,
  input  logic [31:0]           instrD,
  input  logic                  RegWriteW,
  input  logic [REGS_POWER-1:0] rdW,
  input  logic [31:0]           resultW,
  input  logic                  stallE,
  input  logic                  flushE,
  output logic [REGS_POWER-1:0] rs1D,
  output logic [REGS_POWER-1:0] rs2D,
  output logic [31:0]           pcE,
  output logic [31:0]           rs1valE,
  output logic [31:0]           rs2valE,
  output logic [31:0]           immE,
  output logic [REGS_POWER-1:0] rs1E,
  output logic [REGS_POWER-1:0] rs2E,
  output logic [REGS_POWER-1:0] rdE,
  output logic [2:0]            funct3E,
  output logic [3:0]            aluctrlE,
  output logic [1:0]            srcAE,
  output logic                  srcBE,
  output logic                  RegWriteE,
  output logic                  MemReadE,
  output logic                  MemWriteE,
  output logic                  BranchE,
  output logic                  JumpE,
  output logic                  JalrE,
  output logic                  IllegalE
);
  localparam int NREGS = 1 << REGS_POWER;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic [31:0]           rf [NREGS];
  logic [REGS_POWER-1:0] rd;
  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [31:0]           rs1val, rs2val, imm;
  logic [3:0]            aluctrl;
  logic [1:0]            srca;
  logic                  srcb, regwrite, memread, memwrite, branch, jump, jalr, illegal;

  assign rs1D   = instrD[15 +: REGS_POWER];
  assign rs2D   = instrD[20 +: REGS_POWER];
  assign rd     = instrD[7 +: REGS_POWER];
  assign opcode = instrD[6:0];
  assign funct3 = instrD[14:12];

  // Same-cycle writebacks are forwarded so decode never sees a stale operand.
  always_comb begin
    rs1val = '0;
    rs2val = '0;
    if (rs1D != '0)
      rs1val = (RegWriteW && rdW != '0 && rdW == rs1D) ? resultW : rf[rs1D];
    if (rs2D != '0)
      rs2val = (RegWriteW && rdW != '0 && rdW == rs2D) ? resultW : rf[rs2D];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (RegWriteW && rdW != '0) begin
      rf[rdW] <= resultW;
    end
  end

  always_comb begin
    imm      = '0;
    aluctrl  = '0;
    srca     = 2'd0;
    srcb     = 1'b0;
    regwrite = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    jalr     = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_LUI: begin
        imm = {instrD[31:12], 12'b0};
        srca = 2'd2; srcb = 1'b1; regwrite = 1'b1;
      end
      OP_AUIPC: begin
        imm = {instrD[31:12], 12'b0};
        srca = 2'd1; srcb = 1'b1; regwrite = 1'b1;
      end
      OP_JAL: begin
        imm = {{11{instrD[31]}}, instrD[31], instrD[19:12], instrD[20], instrD[30:21], 1'b0};
        srca = 2'd1; srcb = 1'b1; jump = 1'b1; regwrite = 1'b1;
      end
      OP_JALR: begin
        imm = {{20{instrD[31]}}, instrD[31:20]};
        srcb = 1'b1; jalr = 1'b1; regwrite = 1'b1;
      end
      OP_BRANCH: begin
        imm = {{19{instrD[31]}}, instrD[31], instrD[7], instrD[30:25], instrD[11:8], 1'b0};
        aluctrl = 4'b1000; branch = 1'b1;
      end
      OP_LOAD: begin
        imm = {{20{instrD[31]}}, instrD[31:20]};
        srcb = 1'b1; memread = 1'b1; regwrite = 1'b1;
      end
      OP_STORE: begin
        imm = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
        srcb = 1'b1; memwrite = 1'b1;
      end
      OP_OPIMM: begin
        imm = {{20{instrD[31]}}, instrD[31:20]};
        // Only shifts-right use bit 30 (SRAI); elsewhere it is immediate data.
        aluctrl = {(funct3 == 3'b101) ? instrD[30] : 1'b0, funct3};
        srcb = 1'b1; regwrite = 1'b1;
      end
      OP_OP: begin
        if (instrD[31:25] == 7'b0000000 || instrD[31:25] == 7'b0100000) begin
          aluctrl = {instrD[30], funct3};
          regwrite = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = (instrD != 32'b0);
    endcase
    if (rd == '0) regwrite = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset || flushE) begin
      pcE <= '0; rs1valE <= '0; rs2valE <= '0; immE <= '0;
      rs1E <= '0; rs2E <= '0; rdE <= '0; funct3E <= '0;
      aluctrlE <= '0; srcAE <= '0; srcBE <= 1'b0;
      RegWriteE <= 1'b0; MemReadE <= 1'b0; MemWriteE <= 1'b0;
      BranchE <= 1'b0; JumpE <= 1'b0; JalrE <= 1'b0; IllegalE <= 1'b0;
    end else if (!stallE) begin
      pcE <= pcD; rs1valE <= rs1val; rs2valE <= rs2val; immE <= imm;
      rs1E <= rs1D; rs2E <= rs2D; rdE <= rd; funct3E <= funct3;
      aluctrlE <= aluctrl; srcAE <= srca; srcBE <= srcb;
      RegWriteE <= regwrite; MemReadE <= memread; MemWriteE <= memwrite;
      BranchE <= branch; JumpE <= jump; JalrE <= jalr; IllegalE <= illegal;
    end
  end
endmodule

// File: tb/tb_decode.sv
// tb/tb_decode.sv - directed-vector bench for decode
module tb_decode;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pcD, instrD, resultW;
  logic        RegWriteW, stallE, flushE;
  logic [4:0]  rdW, rs1D, rs2D, rs1E, rs2E, rdE;
  logic [31:0] pcE, rs1valE, rs2valE, immE;
  logic [2:0]  funct3E;
  logic [3:0]  aluctrlE;
  logic [1:0]  srcAE;
  logic        srcBE, RegWriteE, MemReadE, MemWriteE, BranchE, JumpE, JalrE, IllegalE;

  int vectors = 0;
  int miscompares = 0;

  decode dut (
    .clk(clk), .reset(reset), .pcD(pcD), .instrD(instrD),
    .RegWriteW(RegWriteW), .rdW(rdW), .resultW(resultW),
    .stallE(stallE), .flushE(flushE), .rs1D(rs1D), .rs2D(rs2D),
    .pcE(pcE), .rs1valE(rs1valE), .rs2valE(rs2valE), .immE(immE),
    .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .funct3E(funct3E),
    .aluctrlE(aluctrlE), .srcAE(srcAE), .srcBE(srcBE),
    .RegWriteE(RegWriteE), .MemReadE(MemReadE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE), .IllegalE(IllegalE)
  );

  always #5 clk = ~clk;

  // flags = {RegWrite, MemRead, MemWrite, Branch, Jump, Jalr, Illegal}
  function automatic logic [31:0] flags();
    return {25'b0, RegWriteE, MemReadE, MemWriteE, BranchE, JumpE, JalrE, IllegalE};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    instrD = ins;
    pcD    = pc;
    step();
  endtask

  task automatic writeback(input logic [4:0] r, input logic [31:0] v);
    RegWriteW = 1'b1; rdW = r; resultW = v; instrD = 32'h0;
    step();
    RegWriteW = 1'b0; rdW = '0; resultW = '0;
  endtask

  initial begin
    reset = 1'b0; pcD = '0; instrD = '0; RegWriteW = 1'b0; rdW = '0;
    resultW = '0; stallE = 1'b0; flushE = 1'b0;
    step();
    check("reset_pcE", pcE, 32'h0);
    check("reset_flags", flags(), 32'h0);
    reset = 1'b1;

    writeback(5'd1, 32'h100);
    writeback(5'd2, 32'h30);
    writeback(5'd5, 32'h55);

    // addi x1,x0,5
    issue(32'h00500093, 32'h10);
    check("addi_imm", immE, 32'd5);
    check("addi_rd", {27'b0, rdE}, 32'd1);
    check("addi_srcA", {30'b0, srcAE}, 32'd0);
    check("addi_srcB", {31'b0, srcBE}, 32'd1);
    check("addi_alu", {28'b0, aluctrlE}, 32'd0);
    check("addi_flags", flags(), 32'h40);
    check("addi_pc", pcE, 32'h10);

    // add x4,x3,x0 with x3 written in the same cycle
    instrD = 32'h00018233; #1;
    check("rs1D_comb", {27'b0, rs1D}, 32'd3);
    check("rs2D_comb", {27'b0, rs2D}, 32'd0);
    RegWriteW = 1'b1; rdW = 5'd3; resultW = 32'hDEADBEEF;
    step();
    check("bypass_rs1", rs1valE, 32'hDEADBEEF);
    check("bypass_rd", {27'b0, rdE}, 32'd4);
    RegWriteW = 1'b0; rdW = '0; resultW = '0;
    issue(32'h00018233, 32'h14);
    check("array_rs1", rs1valE, 32'hDEADBEEF);

    // write to x0 is not bypassed and not stored
    RegWriteW = 1'b1; rdW = 5'd0; resultW = 32'd7;
    issue(32'h00500093, 32'h18);
    check("x0_bypass", rs1valE, 32'h0);
    RegWriteW = 1'b0; resultW = '0;
    issue(32'h00500093, 32'h1C);
    check("x0_array", rs1valE, 32'h0);

    // srai x1,x1,3 keeps bit30; addi with imm bit 30 set does not
    issue(32'h4030D093, 32'h20);
    check("srai_alu", {28'b0, aluctrlE}, 32'hD);
    issue(32'h40000093, 32'h24);
    check("addi_b30_alu", {28'b0, aluctrlE}, 32'h0);
    check("addi_b30_imm", immE, 32'h400);

    // beq x0,x0,-4
    issue(32'hFE000EE3, 32'h28);
    check("beq_imm", immE, 32'hFFFFFFFC);
    check("beq_flags", flags(), 32'h08);
    check("beq_alu", {28'b0, aluctrlE}, 32'h8);
    check("beq_srcB", {31'b0, srcBE}, 32'd0);

    // jal x1,-1048576
    issue(32'h800000EF, 32'h2C);
    check("jal_imm", immE, 32'hFFF00000);
    check("jal_flags", flags(), 32'h44);
    check("jal_srcA", {30'b0, srcAE}, 32'd1);

    // sub x5,x1,x2, then stall 2 cycles while x1 is rewritten
    issue(32'h402082B3, 32'h30);
    check("sub_rs1", rs1valE, 32'h100);
    check("sub_rs2", rs2valE, 32'h30);
    check("sub_alu", {28'b0, aluctrlE}, 32'h8);
    stallE = 1'b1;
    RegWriteW = 1'b1; rdW = 5'd1; resultW = 32'h999;
    issue(32'h00500093, 32'h34);
    RegWriteW = 1'b0; rdW = '0; resultW = '0;
    issue(32'h00500093, 32'h38);
    check("stall_rs1", rs1valE, 32'h100);
    check("stall_pc", pcE, 32'h30);
    check("stall_rd", {27'b0, rdE}, 32'd5);
    check("stall_alu", {28'b0, aluctrlE}, 32'h8);
    flushE = 1'b1;
    step();
    check("flush_flags", flags(), 32'h0);
    check("flush_rs1", rs1valE, 32'h0);
    check("flush_pc", pcE, 32'h0);
    check("flush_alu", {28'b0, aluctrlE}, 32'h0);
    stallE = 1'b0; flushE = 1'b0;

    // write during stall landed in the array
    issue(32'h00008193, 32'h3C);
    check("stall_write", rs1valE, 32'h999);

    issue(32'hFFFFFFFF, 32'h40);
    check("illegal_flags", flags(), 32'h01);
    issue(32'h00000000, 32'h44);
    check("bubble_flags", flags(), 32'h0);

    // add x6,x5,x0 before and after an asynchronous reset
    issue(32'h00028333, 32'h48);
    check("x5_before", rs1valE, 32'h55);
    #2 reset = 1'b0;
    #1;
    check("async_pc", pcE, 32'h0);
    check("async_rs1", rs1valE, 32'h0);
    check("async_flags", flags(), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    issue(32'h00028333, 32'h4C);
    check("x5_after", rs1valE, 32'h0);
    check("after_pc", pcE, 32'h4C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
